// File: rtl/draw_multi_char_16x16_pkg.sv
// draw_multi_char_16x16_pkg: shared VGA widths, glyph geometry, colours and blink states
package draw_multi_char_16x16_pkg;
  localparam int HV_W   = 11;
  localparam int RGB_W  = 12;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int GRID   = 16;
  localparam int WIN_W  = CHAR_W * GRID;
  localparam int WIN_H  = CHAR_H * GRID;
  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] RGB_WHITE = 12'hFFF;
  typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_state_t;
  function automatic logic in_span(input logic [HV_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction
endpackage

// File: rtl/draw_multi_char_16x16_vga_delay.sv
// vga_delay: reset-clearable shift pipeline delaying a bus by CLK_DEL clocks
module vga_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  logic [WIDTH-1:0] r_pipe [CLK_DEL];
  // shift the bus one stage per clock, cleared at once by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < CLK_DEL; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_dout = r_pipe[CLK_DEL-1];
endmodule

// File: rtl/draw_multi_char_16x16.sv
// draw_multi_char_16x16: overlays a blinking 16x16-character text window on the video stream
module draw_multi_char_16x16 import draw_multi_char_16x16_pkg::*; #(
  parameter int               XPOS         = 400,
  parameter int               YPOS         = 100,
  parameter logic [RGB_W-1:0] TEXT_COLOR   = RGB_WHITE,
  parameter int               BLINK_FRAMES = 30
)(
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [HV_W-1:0]  hcount_in,
  input  logic [HV_W-1:0]  vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             blink_en,
  input  logic [6:0]       char_code,
  input  logic [7:0]       char_pixels,
  output logic [7:0]       char_xy,
  output logic [10:0]      font_addr,
  output logic [HV_W-1:0]  hcount_out,
  output logic [HV_W-1:0]  vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out
);
  localparam int CW = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
  logic [6:0]       w_rel_x;
  logic [7:0]       w_rel_y;
  logic             w_in_area;
  logic [25:0]      w_tim;
  logic [17:0]      w_p2;
  logic             w_blank2;
  logic             w_in2;
  logic [2:0]       w_bit2;
  logic [RGB_W-1:0] w_rgb2;
  logic             w_pix;
  logic             w_show;
  logic             w_rise;
  blink_state_t     r_state, w_state_nxt;
  logic [CW-1:0]    r_frame_cnt, w_cnt_nxt;
  logic             r_vsync_d;
  assign w_rel_x   = 7'(hcount_in - HV_W'(XPOS));
  assign w_rel_y   = 8'(vcount_in - HV_W'(YPOS));
  assign w_in_area = in_span(hcount_in, XPOS, WIN_W) && in_span(vcount_in, YPOS, WIN_H);
  assign char_xy   = {w_rel_y[7:4], w_rel_x[6:3]};
  // font ROM address: character code plus glyph line within the cell
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) font_addr <= '0;
    else        font_addr <= {char_code, w_rel_y[3:0]};
  end
  vga_delay #(.WIDTH(26), .CLK_DEL(3)) u_tim_dly (
    .i_clk   (pclk),
    .i_rst_n (rst_n),
    .i_din   ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .o_dout  (w_tim)
  );
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = w_tim;
  vga_delay #(.WIDTH(18), .CLK_DEL(2)) u_pix_dly (
    .i_clk   (pclk),
    .i_rst_n (rst_n),
    .i_din   ({hblnk_in | vblnk_in, w_in_area, w_rel_x[2:0], rgb_in}),
    .o_dout  (w_p2)
  );
  assign {w_blank2, w_in2, w_bit2, w_rgb2} = w_p2;
  assign w_pix  = char_pixels[3'd7 - w_bit2];
  assign w_show = (r_state == SHOW) | ~blink_en;
  assign w_rise = vsync_in & ~r_vsync_d;
  // final mix: blanking wins, then lit glyph pixels, else background
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) rgb_out <= '0;
    else        rgb_out <= w_blank2 ? RGB_BLACK : (w_in2 & w_pix & w_show) ? TEXT_COLOR : w_rgb2;
  end
  // blink state, frame counter and vsync edge-detect registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SHOW;
      r_frame_cnt <= '0;
      r_vsync_d   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_vsync_d   <= vsync_in;
    end
  end
  // count frames on vsync rise; toggle visibility every BLINK_FRAMES frames
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_frame_cnt;
    if (BLINK_FRAMES == 0) begin
      w_state_nxt = SHOW;
      w_cnt_nxt   = '0;
    end else if (w_rise) begin
      w_cnt_nxt   = (r_frame_cnt == LAST) ? '0 : r_frame_cnt + 1'b1;
      w_state_nxt = (r_frame_cnt != LAST) ? r_state : (r_state == SHOW) ? HIDE : SHOW;
    end
  end
endmodule

// File: doc/draw_multi_char_16x16.md
Name: draw_multi_char_16x16

Overview:
- Pixel-pipeline stage in the VGA chain that overlays a 16x16-character text window on the incoming video stream.
- It drives the 8-bit cell address consumed by multi_char_rom_16x16 and receives the 7-bit character code back combinationally.
- It forms the font-ROM address, gets the glyph row from the synchronous font ROM, and emits delayed timing plus overlaid RGB to the next stage.
- Each glyph is 8x16 px, so the window is 128x256 px.

Parameters:
XPOS, 400, left pixel column of text window
YPOS, 100, top pixel row of text window
TEXT_COLOR, 12'hFFF, RGB444 of foreground text pixels
BLINK_FRAMES, 30, frames per blink half-period (0 = blinking disabled)

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hcount_in  in  11  horizontal pixel counter
vcount_in  in  11  vertical line counter
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
rgb_in  in  12  background RGB444
blink_en  in  1  1 = text blinks, 0 = text steady
char_code  in  7  code from multi_char_rom_16x16, same cycle
char_pixels  in  8  glyph row from font ROM, 1-cycle read latency, MSB = leftmost pixel
char_xy  out  8  {row[3:0], col[3:0]} cell address, combinational from hcount_in/vcount_in
font_addr  out  11  {char_code, line[3:0]}, registered
hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed by 3 clocks
rgb_out  out  12  overlaid RGB, registered

Behaviour:
- Reset (asynchronous, rst_n=0): every registered output and internal register goes to 0.
  - This includes font_addr, all *_out signals, rgb_out, the frame counter and the blink phase.
  - Reset asserted mid-frame clears the pipeline immediately.
  - After release, the first valid rgb_out appears 3 edges after the first sampled input.
- Stage 0 (combinational):
  - rel_x = hcount_in - XPOS, rel_y = vcount_in - YPOS, both 11 bits unsigned.
  - in_area = (hcount_in >= XPOS) && (hcount_in < XPOS+128) && (vcount_in >= YPOS) && (vcount_in < YPOS+256).
  - char_xy = {rel_y[7:4], rel_x[6:3]}. Outside the window its value is don't-care but must be deterministic (same formula).
- Stage 1 (edge 1):
  - font_addr <= {char_code, rel_y[3:0]}.
  - Register timing, rgb_in, in_area and bit_idx = rel_x[2:0].
- Stage 2 (edge 2):
  - char_pixels now corresponds to the stage-1 font_addr.
  - Register the stage-1 timing, rgb, in_area and bit_idx a second time.
- Stage 3 (edge 3):
  - pix = char_pixels[7 - bit_idx].
  - rgb_out <= 0 if hblnk|vblnk (stage 2);
  - else TEXT_COLOR if in_area & pix & show;
  - else rgb (stage 2).
  - Timing outputs are registered in the same edge.
- Latency: exactly 3 pclk cycles for every output relative to its input.
- Blink FSM: states SHOW and HIDE; show = (state==SHOW) | ~blink_en.
  - frame_cnt increments on each vsync_in rising edge (vsync_in registered once for edge detect).
  - When frame_cnt == BLINK_FRAMES-1 on a rising edge: frame_cnt <= 0 and the state toggles.
  - BLINK_FRAMES=0: the state is held in SHOW and the counter is held at 0.
  - blink_en low does not stop the counter; it only forces show=1.
- Boundaries:
  - hcount = XPOS+127 is the last text column; XPOS+128 is background.
  - vcount = YPOS+255 is the last row.
  - A window running past the visible area is clipped only by blanking.
  - Counter width is ceil(log2(BLINK_FRAMES+1)); frame_cnt must never exceed BLINK_FRAMES-1.

Decomposition:
- Shared VGA package: H/V counter widths (11), RGB width (12), CHAR_W=8, CHAR_H=16, GRID=16, RGB444 colour constants.
- Sub-module: vga_delay (parametric WIDTH, CLK_DEL) for the 3-stage timing/rgb pipeline. Reuse it for all delayed signals.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Deassert rst_n mid-line -> first non-zero rgb_out exactly 3 clocks after its input.
- Addressing (XPOS=400, YPOS=100):
  - Input: hcount=448, vcount=133.
  - Required: char_xy=8'h26 in the same cycle.
  - Required: with char_code=7'h4D, font_addr=11'h4D1 one clock later ({4D,line 1}).
- Pixel select: char_pixels=8'b1000_0001 at hcount=448 and hcount=455 -> rgb_out=12'hFFF for both, 3 clocks later. hcount=449..454 -> rgb_in passed through.
- Window edges: hcount=399 and 528, or vcount=99 and 356 -> rgb_out=rgb_in regardless of char_pixels. hblnk=1 inside the window -> rgb_out=0.
- Blink (BLINK_FRAMES=2, blink_en=1):
  - Text visible in frames 0-1, hidden in frames 2-3, visible from frame 4.
  - blink_en=0 -> visible in all frames.
- BLINK_FRAMES=0 with blink_en=1 -> text never hidden and frame_cnt stays 0 across 10 vsync pulses.
